// File: rtl/alu_regfile_pkg.sv
// rtl/alu_regfile_pkg.sv - shared widths and ALU function encodings for alu_regfile
package alu_regfile_pkg;

    localparam int WIDTH_WORD_DEF = 8;
    localparam int WIDTH_SEG_DEF  = 4;

    // Encodings match instruction bits 14:12 when bit 15 selects the ALU class.
    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_NOT = 3'b100,
        FN_MV  = 3'b101,
        FN_LT  = 3'b110,
        FN_EQ  = 3'b111
    } alu_fn_e;

endpackage

// File: rtl/alu_regfile_regs.sv
// rtl/alu_regfile_regs.sv - register array with two write ports and two combinational read ports
module alu_regfile_regs
    import alu_regfile_pkg::*;
#(
    parameter int WIDTH_WORD = WIDTH_WORD_DEF,
    parameter int WIDTH_SEG  = WIDTH_SEG_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we0,
    input  logic [WIDTH_SEG-1:0]  wa0,
    input  logic [WIDTH_WORD-1:0] wd0,
    input  logic                  we1,
    input  logic [WIDTH_SEG-1:0]  wa1,
    input  logic [WIDTH_WORD-1:0] wd1,
    input  logic [WIDTH_SEG-1:0]  ra0,
    output logic [WIDTH_WORD-1:0] rd0,
    input  logic [WIDTH_SEG-1:0]  ra1,
    output logic [WIDTH_WORD-1:0] rd1
);

    localparam int DEPTH = 1 << WIDTH_SEG;

    logic [WIDTH_WORD-1:0] mem [DEPTH];

    // Port 1 is written last so it wins an address collision with port 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0) begin
                mem[wa0] <= wd0;
            end
            if (we1) begin
                mem[wa1] <= wd1;
            end
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - dual-port register file feeding a combinational ALU
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int WIDTH_WORD = WIDTH_WORD_DEF,
    parameter int WIDTH_SEG  = WIDTH_SEG_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [WIDTH_SEG-1:0]    wa0,
    input  logic [WIDTH_WORD-1:0]   wd0,
    input  logic [WIDTH_SEG-1:0]    wa1,
    input  logic [WIDTH_WORD-1:0]   wd1,
    input  logic [WIDTH_SEG-1:0]    ra0,
    output logic [WIDTH_WORD-1:0]   rd0,
    input  logic [WIDTH_SEG-1:0]    ra1,
    output logic [WIDTH_WORD-1:0]   rd1,
    output logic [2*WIDTH_WORD-1:0] rdd,
    input  logic                    alu_en,
    input  logic [2:0]              alu_fn,
    output logic [WIDTH_WORD-1:0]   y,
    output logic                    carry
);

    logic [WIDTH_WORD:0] sum;

    alu_regfile_regs #(
        .WIDTH_WORD (WIDTH_WORD),
        .WIDTH_SEG  (WIDTH_SEG)
    ) u_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1),
        .ra0   (ra0),
        .rd0   (rd0),
        .ra1   (ra1),
        .rd1   (rd1)
    );

    assign rdd = {rd1, rd0};
    assign sum = {1'b0, rd0} + {1'b0, rd1};

    // Operand a is always read port 0, b is read port 1.
    always_comb begin
        y     = '0;
        carry = 1'b0;
        if (alu_en) begin
            case (alu_fn_e'(alu_fn))
                FN_ADD: begin
                    y     = sum[WIDTH_WORD-1:0];
                    carry = sum[WIDTH_WORD];
                end
                FN_SUB: begin
                    y     = rd0 - rd1;
                    carry = (rd0 < rd1);
                end
                FN_AND: y = rd0 & rd1;
                FN_OR:  y = rd0 | rd1;
                FN_NOT: y = ~rd0;
                FN_MV:  y = rd0;
                FN_LT:  carry = (rd0 < rd1);
                FN_EQ:  carry = (rd0 == rd1);
                default: begin
                    y     = '0;
                    carry = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - scoreboard bench for alu_regfile
module tb_alu_regfile;

    logic        clk = 1'b0;
    logic        rst_n, we0, we1, alu_en;
    logic [3:0]  wa0, wa1, ra0, ra1;
    logic [7:0]  wd0, wd1, rd0, rd1, y;
    logic [15:0] rdd;
    logic [2:0]  alu_fn;
    logic        carry;

    typedef struct {
        string       tag;
        logic [15:0] rdd;
        logic [7:0]  y;
        logic        c;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model [16];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    alu_regfile dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we0    (we0),
        .we1    (we1),
        .wa0    (wa0),
        .wd0    (wd0),
        .wa1    (wa1),
        .wd1    (wd1),
        .ra0    (ra0),
        .rd0    (rd0),
        .ra1    (ra1),
        .rd1    (rd1),
        .rdd    (rdd),
        .alu_en (alu_en),
        .alu_fn (alu_fn),
        .y      (y),
        .carry  (carry)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input logic [7:0] a, input logic [7:0] b, input logic en,
                                    input logic [2:0] fn, output logic [7:0] ry, output logic rc);
        logic [8:0] s;
        ry = 8'h00;
        rc = 1'b0;
        if (en) begin
            case (fn)
                3'd0: begin s = {1'b0, a} + {1'b0, b}; ry = s[7:0]; rc = s[8]; end
                3'd1: begin ry = a - b; rc = (a < b); end
                3'd2: ry = a & b;
                3'd3: ry = a | b;
                3'd4: ry = ~a;
                3'd5: ry = a;
                3'd6: rc = (a < b);
                default: rc = (a == b);
            endcase
        end
    endfunction

    // Push the model's prediction, let the combinational outputs settle, then pop and compare.
    task automatic probe(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                         input logic en, input logic [2:0] fn);
        exp_t e;
        logic [7:0] ey;
        logic ec;
        ra0 = a0; ra1 = a1; alu_en = en; alu_fn = fn;
        alu_ref(model[a0], model[a1], en, fn, ey, ec);
        e.tag = tag; e.rdd = {model[a1], model[a0]}; e.y = ey; e.c = ec;
        sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        check({e.tag, "_rdd"}, {16'h0, rdd}, {16'h0, e.rdd});
        check({e.tag, "_y"}, {24'h0, y}, {24'h0, e.y});
        check({e.tag, "_c"}, {31'h0, carry}, {31'h0, e.c});
    endtask

    task automatic wr(input logic e0, input logic [3:0] a0, input logic [7:0] d0,
                      input logic e1, input logic [3:0] a1, input logic [7:0] d1);
        @(negedge clk);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
        end else begin
            if (e0) model[a0] = d0;
            if (e1) model[a1] = d1;
        end
        #1;
        we0 = 1'b0; we1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        ra0 = '0; ra1 = '0; alu_en = 1'b0; alu_fn = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i += 2) probe($sformatf("rst_r%0d", i), 4'(i), 4'(i + 1), 1'b0, 3'd0);

        // Reset asserted during a write must win.
        wr(1'b1, 4'd3, 8'h55, 1'b0, 4'd0, 8'h00);
        probe("preload", 4'd3, 4'd0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        wr(1'b1, 4'd3, 8'hAA, 1'b0, 4'd0, 8'h00);
        rst_n = 1'b1;
        check("rst_wr_model", {24'h0, model[3]}, 32'h0);
        probe("rst_wr", 4'd3, 4'd0, 1'b0, 3'd0);
        check("rst_rd0", {24'h0, rd0}, 32'h0);

        wr(1'b1, 4'd14, 8'h12, 1'b1, 4'd15, 8'h00);
        probe("pc_pair", 4'd14, 4'd15, 1'b0, 3'd0);
        check("pc_rdd", {16'h0, rdd}, 32'h0012);

        wr(1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h22);
        probe("collide", 4'd5, 4'd5, 1'b0, 3'd0);
        check("collide_rd0", {24'h0, rd0}, 32'h22);

        wr(1'b1, 4'd3, 8'hF0, 1'b1, 4'd4, 8'h20);
        probe("add", 4'd3, 4'd4, 1'b1, 3'd0);
        check("add_y", {23'h0, carry, y}, 32'h110);
        wr(1'b1, 4'd3, 8'h03, 1'b1, 4'd4, 8'h04);
        probe("sub", 4'd3, 4'd4, 1'b1, 3'd1);
        check("sub_y", {23'h0, carry, y}, 32'h1FF);

        wr(1'b1, 4'd3, 8'd1, 1'b1, 4'd2, 8'd100);
        probe("lt_true", 4'd3, 4'd2, 1'b1, 3'd6);
        check("lt_true_c", {31'h0, carry}, 32'h1);
        wr(1'b1, 4'd3, 8'd100, 1'b0, 4'd0, 8'h00);
        probe("lt_eq", 4'd3, 4'd2, 1'b1, 3'd6);
        check("lt_eq_c", {31'h0, carry}, 32'h0);
        probe("eq", 4'd3, 4'd2, 1'b1, 3'd7);
        check("eq_c", {31'h0, carry}, 32'h1);
        probe("en_off", 4'd3, 4'd2, 1'b0, 3'd7);

        // Read-after-write: old value up to the edge, new value after it.
        wr(1'b1, 4'd1, 8'h33, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        we0 = 1'b1; wa0 = 4'd1; wd0 = 8'h08;
        probe("raw_before", 4'd1, 4'd0, 1'b0, 3'd0);
        check("raw_before_rd0", {24'h0, rd0}, 32'h33);
        @(posedge clk);
        model[1] = 8'h08;
        #1;
        we0 = 1'b0;
        probe("raw_after", 4'd1, 4'd0, 1'b0, 3'd0);
        check("raw_after_rd0", {24'h0, rd0}, 32'h08);

        for (int n = 0; n < 60; n++) begin
            wr(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
            probe($sformatf("rnd%0d", n), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  3'($urandom));
        end
        for (int f = 0; f < 8; f++) begin
            probe($sformatf("fn%0d_same", f), 4'd7, 4'd7, 1'b1, 3'(f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
